// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional odd parity, stop bits.
// Supports one-shot parity corruption for error-path testing.
module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  parity_en,
  input  logic                  err_inj_en,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  frame_done,
  output logic                  err_inj_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudOne  = CntW'(1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic [BitW-1:0] BitOne   = BitW'(1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]       bitc_q, bitc_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  inj_q, inj_d;
  logic                  tx_serial_q, tx_serial_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_inj_done_q, err_inj_done_d;
  logic                  bit_end;

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bitc_d    = bitc_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    inj_d     = inj_q;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d  = StStart;
          baud_d   = '0;
          bitc_d   = '0;
          shift_d  = tx_data;
          par_en_d = parity_en;
          // Injection only means something when a parity bit is actually sent.
          inj_d     = parity_en & err_inj_en;
          par_bit_d = (~^tx_data) ^ (parity_en & err_inj_en);
        end
      end
      StStart, StData, StParity, StStop: begin
        if (!bit_end) begin
          baud_d = baud_q + BaudOne;
        end else begin
          baud_d = '0;
          if (state_q == StStart) begin
            state_d = StData;
            bitc_d  = '0;
          end else if (state_q == StData) begin
            shift_d = shift_q >> 1;
            if (bitc_q == DataLast) begin
              bitc_d  = '0;
              state_d = par_en_q ? StParity : StStop;
            end else begin
              bitc_d = bitc_q + BitOne;
            end
          end else if (state_q == StParity) begin
            state_d = StStop;
            bitc_d  = '0;
          end else if (bitc_q == StopLast) begin
            state_d = StIdle;
            bitc_d  = '0;
          end else begin
            bitc_d = bitc_q + BitOne;
          end
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bitc_d  = '0;
      end
    endcase
  end

  // Outputs are computed from next state so they can be registered without a cycle of lag.
  always_comb begin
    tx_serial_d = 1'b1;
    case (state_d)
      StStart:  tx_serial_d = 1'b0;
      StData:   tx_serial_d = shift_d[0];
      StParity: tx_serial_d = par_bit_d;
      default:  tx_serial_d = 1'b1;
    endcase
    frame_done_d   = (state_d == StStop) && (baud_d == BaudLast) && (bitc_d == StopLast);
    err_inj_done_d = (state_d == StParity) && (baud_d == BaudLast) && inj_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      baud_q         <= '0;
      bitc_q         <= '0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
      inj_q          <= 1'b0;
      tx_serial_q    <= 1'b1;
      frame_done_q   <= 1'b0;
      err_inj_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bitc_q         <= bitc_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_bit_q      <= par_bit_d;
      inj_q          <= inj_d;
      tx_serial_q    <= tx_serial_d;
      frame_done_q   <= frame_done_d;
      err_inj_done_q <= err_inj_done_d;
    end
  end

  assign tx_serial    = tx_serial_q;
  assign frame_done   = frame_done_q;
  assign err_inj_done = err_inj_done_q;
  assign tx_ready     = (state_q == StIdle);
  assign tx_busy      = (state_q != StIdle);

endmodule
